// File: rtl/sd_cmd_sequencer_pkg.sv
// Shared definitions for the SD command-line sequencer: register map,
// response-type encoding, FSM state encoding and error-flag bit positions.
package sd_cmd_sequencer_pkg;

  localparam logic [11:0] ADDR_ARG_LO = 12'h008;
  localparam logic [11:0] ADDR_ARG_HI = 12'h00A;
  localparam logic [11:0] ADDR_CMD    = 12'h00E;

  // Only "no response" changes sequencing; every other encoding waits for a frame.
  localparam logic [1:0] RESP_NONE = 2'b00;

  localparam int ERR_W       = 3;
  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_CRC     = 1;
  localparam int ERR_INDEX   = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_SENT = 3'd2,
    ST_WAIT_RESP = 3'd3,
    ST_DONE      = 3'd4
  } seq_state_e;

  typedef struct packed {
    logic [5:0] cmd_index;
    logic       idx_chk_en;
    logic       crc_chk_en;
    logic [1:0] resp_type;
  } cmd_cfg_t;

  function automatic logic [ERR_W-1:0] resp_errors(
    input logic       crc_chk_en,
    input logic       idx_chk_en,
    input logic [5:0] cmd_index,
    input logic       crc_err,
    input logic [5:0] resp_index
  );
    logic [ERR_W-1:0] err;
    err            = '0;
    err[ERR_CRC]   = crc_chk_en & crc_err;
    err[ERR_INDEX] = idx_chk_en & (resp_index != cmd_index);
    return err;
  endfunction

endpackage

// File: rtl/sd_timeout_counter.sv
// Response timeout counter: counts qualified ticks up to TICKS and holds
// there, flagging expiry until cleared.
module sd_timeout_counter #(
  parameter int TICKS = 64
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int W = $clog2(TICKS + 1);
  localparam logic [W-1:0] LIMIT = W'(TICKS);

  logic [W-1:0] count;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/sd_cmd_sequencer.sv
// SD CMD-line sequencer: register-programmed command issue, PHY handshake,
// response capture with CRC/index checking and card-clock based timeout.
//
// state      | meaning
// IDLE       | no command in flight; registers writable
// ISSUE      | one-cycle phy_start pulse
// WAIT_SENT  | waiting for the PHY to finish shifting the command frame
// WAIT_RESP  | waiting for a response frame or timeout
// DONE       | one-cycle cmd_complete pulse
module sd_cmd_sequencer
  import sd_cmd_sequencer_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [11:0] reg_address,
  input  logic [31:0] reg_wr_data,
  input  logic        reg_wr_en,
  input  logic        card_tick,
  output logic        phy_start,
  output logic [5:0]  phy_cmd_index,
  output logic [31:0] phy_argument,
  output logic [1:0]  phy_resp_type,
  input  logic        phy_sent,
  input  logic        phy_resp_valid,
  input  logic [5:0]  phy_resp_index,
  input  logic [31:0] phy_resp_data,
  input  logic        phy_crc_err,
  output logic        cmd_inhibit,
  output logic        cmd_complete,
  output logic [2:0]  err_status,
  output logic [31:0] resp_reg
);

  seq_state_e state, state_next;

  cmd_cfg_t         cfg_q;
  cmd_cfg_t         cmd_cfg;
  logic [31:0]      arg_q;
  logic [ERR_W-1:0] err_q;
  logic [31:0]      resp_q;

  logic             accept_cmd;
  logic             arg_lo_we;
  logic             arg_hi_we;
  logic             load_resp;
  logic             clr_timer;
  logic [ERR_W-1:0] err_set;
  logic             timer_tick;
  logic             timer_expired;

  // Command-word bits outside the decoded fields are reserved.
  logic unused_wr_bits;
  assign unused_wr_bits = ^{reg_wr_data[31:16], reg_wr_data[7:5], reg_wr_data[2]};

  assign cmd_cfg = {reg_wr_data[13:8], reg_wr_data[4], reg_wr_data[3], reg_wr_data[1:0]};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    accept_cmd   = 1'b0;
    arg_lo_we    = 1'b0;
    arg_hi_we    = 1'b0;
    load_resp    = 1'b0;
    clr_timer    = 1'b0;
    err_set      = '0;
    phy_start    = 1'b0;
    cmd_complete = 1'b0;
    cmd_inhibit  = 1'b1;

    unique case (state)
      ST_IDLE: begin
        cmd_inhibit = 1'b0;
        if (reg_wr_en) begin
          arg_lo_we = (reg_address == ADDR_ARG_LO);
          arg_hi_we = (reg_address == ADDR_ARG_HI);
          if (reg_address == ADDR_CMD) begin
            accept_cmd = 1'b1;
            state_next = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        phy_start  = 1'b1;
        state_next = ST_WAIT_SENT;
      end
      ST_WAIT_SENT: begin
        if (phy_sent) begin
          if (cfg_q.resp_type == RESP_NONE) begin
            state_next = ST_DONE;
          end else begin
            clr_timer  = 1'b1;
            state_next = ST_WAIT_RESP;
          end
        end
      end
      ST_WAIT_RESP: begin
        // A response landing on the expiry cycle still counts as a response.
        if (phy_resp_valid) begin
          load_resp  = 1'b1;
          err_set    = resp_errors(cfg_q.crc_chk_en, cfg_q.idx_chk_en, cfg_q.cmd_index,
                                   phy_crc_err, phy_resp_index);
          state_next = ST_DONE;
        end else if (timer_expired) begin
          err_set[ERR_TIMEOUT] = 1'b1;
          state_next           = ST_DONE;
        end
      end
      ST_DONE: begin
        cmd_complete = 1'b1;
        state_next   = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      arg_q  <= '0;
      cfg_q  <= '0;
      err_q  <= '0;
      resp_q <= '0;
    end else begin
      if (arg_lo_we) begin
        arg_q[15:0] <= reg_wr_data[15:0];
      end
      if (arg_hi_we) begin
        arg_q[31:16] <= reg_wr_data[15:0];
      end
      if (accept_cmd) begin
        cfg_q <= cmd_cfg;
        err_q <= '0;
      end else begin
        err_q <= err_q | err_set;
      end
      if (load_resp) begin
        resp_q <= phy_resp_data;
      end
    end
  end

  assign timer_tick = card_tick && (state == ST_WAIT_RESP);

  sd_timeout_counter #(
    .TICKS (TIMEOUT_TICKS)
  ) u_timeout (
    .CLK     (CLK),
    .RESET   (RESET),
    .clear   (clr_timer),
    .tick    (timer_tick),
    .expired (timer_expired)
  );

  assign phy_cmd_index = cfg_q.cmd_index;
  assign phy_argument  = arg_q;
  assign phy_resp_type = cfg_q.resp_type;
  assign err_status    = err_q;
  assign resp_reg      = resp_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Scoreboard bench for sd_cmd_sequencer: stimulus pushes expected PHY frames
// and completions; a negedge monitor pops and compares them.
module tb_sd_cmd_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [11:0] reg_address;
  logic [31:0] reg_wr_data;
  logic        reg_wr_en;
  logic        card_tick;
  logic        phy_start;
  logic [5:0]  phy_cmd_index;
  logic [31:0] phy_argument;
  logic [1:0]  phy_resp_type;
  logic        phy_sent;
  logic        phy_resp_valid;
  logic [5:0]  phy_resp_index;
  logic [31:0] phy_resp_data;
  logic        phy_crc_err;
  logic        cmd_inhibit;
  logic        cmd_complete;
  logic [2:0]  err_status;
  logic [31:0] resp_reg;

  always #5 CLK = ~CLK;

  sd_cmd_sequencer #(.TIMEOUT_TICKS(64)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .reg_address    (reg_address),
    .reg_wr_data    (reg_wr_data),
    .reg_wr_en      (reg_wr_en),
    .card_tick      (card_tick),
    .phy_start      (phy_start),
    .phy_cmd_index  (phy_cmd_index),
    .phy_argument   (phy_argument),
    .phy_resp_type  (phy_resp_type),
    .phy_sent       (phy_sent),
    .phy_resp_valid (phy_resp_valid),
    .phy_resp_index (phy_resp_index),
    .phy_resp_data  (phy_resp_data),
    .phy_crc_err    (phy_crc_err),
    .cmd_inhibit    (cmd_inhibit),
    .cmd_complete   (cmd_complete),
    .err_status     (err_status),
    .resp_reg       (resp_reg)
  );

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [1:0]  rt;
    int          cyc;
  } start_t;

  typedef struct packed {
    logic [2:0]  err;
    logic [31:0] resp;
    int          cyc;
  } done_t;

  start_t start_q[$];
  done_t  done_q[$];
  start_t cur;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int tick_cnt = 0;
  int completes = 0;
  int done_ticks = 0;
  bit idle_chk = 1'b0;

  // Reference model of the programmed state
  logic [31:0] m_arg, m_resp;
  logic [5:0]  m_idx;
  logic [1:0]  m_rt;
  logic        m_crc_en, m_idx_en;
  bit          m_busy;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (card_tick) tick_cnt <= tick_cnt + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    start_t se;
    done_t  de;
    if (idle_chk) begin
      chk("inhibit_low_after_done", 64'(cmd_inhibit), 64'd0);
      idle_chk = 1'b0;
    end
    if (phy_start) begin
      chk("start_expected", 64'(start_q.size() != 0), 64'd1);
      if (start_q.size() != 0) begin
        se = start_q.pop_front();
        chk("start_cycle", 64'(cyc), 64'(se.cyc));
        chk("start_cmd_index", 64'(phy_cmd_index), 64'(se.idx));
        chk("start_argument", 64'(phy_argument), 64'(se.arg));
        chk("start_resp_type", 64'(phy_resp_type), 64'(se.rt));
        cur = se;
      end
    end
    if (cmd_complete) begin
      chk("complete_expected", 64'(done_q.size() != 0), 64'd1);
      if (done_q.size() != 0) begin
        de = done_q.pop_front();
        chk("done_err_status", 64'(err_status), 64'(de.err));
        chk("done_resp_reg", 64'(resp_reg), 64'(de.resp));
        if (de.cyc >= 0) chk("done_cycle", 64'(cyc), 64'(de.cyc));
        chk("held_cmd_index", 64'(phy_cmd_index), 64'(cur.idx));
        chk("held_argument", 64'(phy_argument), 64'(cur.arg));
        chk("held_resp_type", 64'(phy_resp_type), 64'(cur.rt));
      end
      done_ticks = tick_cnt;
      completes++;
      idle_chk = 1'b1;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
    card_tick = 1'($urandom_range(0, 1));
  endtask

  task automatic model_reset();
    m_arg = '0; m_resp = '0; m_idx = '0; m_rt = '0;
    m_crc_en = 1'b0; m_idx_en = 1'b0; m_busy = 1'b0;
  endtask

  task automatic write_reg(input logic [11:0] addr, input logic [31:0] data);
    if (!m_busy) begin
      if (addr == 12'h008) m_arg[15:0] = data[15:0];
      if (addr == 12'h00A) m_arg[31:16] = data[15:0];
      if (addr == 12'h00E) begin
        m_rt = data[1:0];
        m_crc_en = data[3];
        m_idx_en = data[4];
        m_idx = data[13:8];
        start_q.push_back('{m_idx, m_arg, m_rt, cyc + 1});
        m_busy = 1'b1;
      end
    end
    reg_address = addr;
    reg_wr_data = data;
    reg_wr_en = 1'b1;
    step();
    reg_wr_en = 1'b0;
  endtask

  task automatic pulse_sent();
    phy_sent = 1'b1;
    step();
    phy_sent = 1'b0;
  endtask

  task automatic noise_resp();
    phy_resp_valid = 1'b1;
    phy_resp_index = 6'($urandom());
    phy_resp_data = $urandom();
    phy_crc_err = 1'($urandom_range(0, 1));
    step();
    phy_resp_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int c0 = completes;
    int n = 0;
    while (completes == c0 && n < 1500) begin
      step();
      n++;
    end
    chk(nm, 64'(completes != c0), 64'd1);
    m_busy = 1'b0;
  endtask

  task automatic respond(input logic [5:0] r_idx, input logic [31:0] r_data, input logic r_crc);
    logic [2:0] e;
    e = {m_idx_en && (r_idx != m_idx), m_crc_en && r_crc, 1'b0};
    m_resp = r_data;
    done_q.push_back('{e, r_data, cyc + 1});
    phy_resp_valid = 1'b1;
    phy_resp_index = r_idx;
    phy_resp_data = r_data;
    phy_crc_err = r_crc;
    step();
    phy_resp_valid = 1'b0;
    wait_done("done_after_resp");
  endtask

  task automatic random_respond();
    logic [5:0] r_idx;
    r_idx = ($urandom_range(0, 1) != 0) ? m_idx : 6'($urandom());
    respond(r_idx, $urandom(), 1'($urandom_range(0, 1)));
  endtask

  // mode 0: response, 1: timeout, 2: response on the 64th tick
  task automatic finish_cmd(input int mode, input bit noise);
    int base;
    int n;
    step();
    repeat ($urandom_range(0, 3)) begin
      if (noise) noise_resp();
      else step();
    end
    if (m_rt == 2'b00) begin
      done_q.push_back('{3'b000, m_resp, cyc + 1});
      pulse_sent();
      wait_done("done_no_resp");
      return;
    end
    pulse_sent();
    base = tick_cnt;
    if (mode == 1) begin
      done_q.push_back('{3'b001, m_resp, -1});
      if (noise) begin
        write_reg(12'h00E, $urandom());
        write_reg(12'h008, $urandom());
        pulse_sent();
      end
      wait_done("done_timeout");
      chk("timeout_tick_count", 64'((done_ticks - base) >= 64 && (done_ticks - base) <= 65), 64'd1);
    end else if (mode == 2) begin
      n = 0;
      while (n < 2000 && !((tick_cnt - base) == 63 && card_tick)) begin
        step();
        n++;
      end
      chk("tick63_reached", 64'((tick_cnt - base) == 63), 64'd1);
      random_respond();
    end else begin
      repeat ($urandom_range(0, 20)) step();
      if (noise) begin
        write_reg(12'h00E, $urandom());
        write_reg(12'h00A, $urandom());
        pulse_sent();
      end
      random_respond();
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] a;
    int r;
    RESET = 1'b1;
    reg_address = '0; reg_wr_data = '0; reg_wr_en = 1'b0; card_tick = 1'b0;
    phy_sent = 1'b0; phy_resp_valid = 1'b0; phy_resp_index = '0;
    phy_resp_data = '0; phy_crc_err = 1'b0;
    model_reset();
    repeat (3) step();
    RESET = 1'b0;
    step();
    chk("rst_phy_start", 64'(phy_start), 64'd0);
    chk("rst_cmd_inhibit", 64'(cmd_inhibit), 64'd0);
    chk("rst_cmd_complete", 64'(cmd_complete), 64'd0);
    chk("rst_err_status", 64'(err_status), 64'd0);
    chk("rst_resp_reg", 64'(resp_reg), 64'd0);
    chk("rst_argument", 64'(phy_argument), 64'd0);
    chk("rst_cmd_index", 64'(phy_cmd_index), 64'd0);
    chk("rst_resp_type", 64'(phy_resp_type), 64'd0);

    // Programmed frame, upper write-data bits must not leak into the argument
    write_reg(12'h008, 32'hABCD_0123);
    write_reg(12'h00A, 32'h0000_4567);
    write_reg(12'h00E, 32'h0000_1933);
    step();
    chk("frame_argument", 64'(phy_argument), 64'h4567_0123);
    chk("frame_cmd_index", 64'(phy_cmd_index), 64'd25);
    chk("frame_resp_type", 64'(phy_resp_type), 64'd3);
    chk("frame_inhibit", 64'(cmd_inhibit), 64'd1);
    pulse_sent();
    respond(6'd25, 32'h1111_2222, 1'b0);

    // Index and CRC errors together
    write_reg(12'h00E, 32'h0000_193B);
    step();
    pulse_sent();
    respond(6'd24, 32'hCAFE_F00D, 1'b1);
    chk("idx_crc_err_status", 64'(err_status), 64'b110);
    chk("idx_crc_resp_reg", 64'(resp_reg), 64'hCAFE_F00D);

    // Command write while waiting for a response is ignored
    write_reg(12'h00E, 32'h0000_0512);
    step();
    pulse_sent();
    write_reg(12'h00E, 32'h0000_0A01);
    write_reg(12'h008, 32'h0000_FFFF);
    respond(6'd5, 32'h0BAD_BEEF, 1'b0);

    // No-response command: complete right after phy_sent, resp_reg untouched
    write_reg(12'h00E, 32'h0000_0700);
    finish_cmd(0, 1'b1);
    chk("noresp_err_status", 64'(err_status), 64'd0);
    chk("noresp_resp_reg", 64'(resp_reg), 64'h0BAD_BEEF);

    // Timeout
    write_reg(12'h00E, 32'h0000_0202);
    finish_cmd(1, 1'b0);
    chk("timeout_err_status", 64'(err_status), 64'b001);

    // Response coinciding with the final tick
    write_reg(12'h00E, 32'h0000_0312);
    finish_cmd(2, 1'b0);

    // Reset while waiting for phy_sent aborts without completion
    write_reg(12'h00E, 32'h0000_2A02);
    step();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    model_reset();
    chk("abort_phy_start", 64'(phy_start), 64'd0);
    chk("abort_cmd_inhibit", 64'(cmd_inhibit), 64'd0);
    chk("abort_cmd_complete", 64'(cmd_complete), 64'd0);
    chk("abort_err_status", 64'(err_status), 64'd0);
    chk("abort_resp_reg", 64'(resp_reg), 64'd0);
    chk("abort_argument", 64'(phy_argument), 64'd0);
    chk("abort_cmd_index", 64'(phy_cmd_index), 64'd0);
    chk("abort_resp_type", 64'(phy_resp_type), 64'd0);
    pulse_sent();
    repeat (4) step();

    // Reset beats a simultaneous command write
    RESET = 1'b1;
    reg_address = 12'h00E;
    reg_wr_data = 32'h0000_1102;
    reg_wr_en = 1'b1;
    step();
    RESET = 1'b0;
    reg_wr_en = 1'b0;
    repeat (3) step();
    chk("rst_wins_inhibit", 64'(cmd_inhibit), 64'd0);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) != 0) write_reg(12'h008, $urandom());
      if ($urandom_range(0, 1) != 0) write_reg(12'h00A, $urandom());
      if ($urandom_range(0, 3) == 0) begin
        a = 12'($urandom());
        while (a == 12'h008 || a == 12'h00A || a == 12'h00E) a = 12'($urandom());
        write_reg(a, $urandom());
      end
      if ($urandom_range(0, 3) == 0) noise_resp();
      if ($urandom_range(0, 3) == 0) pulse_sent();
      write_reg(12'h00E, $urandom());
      r = $urandom_range(0, 9);
      finish_cmd((r < 6) ? 0 : ((r < 8) ? 1 : 2), 1'($urandom_range(0, 1)));
    end

    repeat (5) step();
    chk("start_q_drained", 64'(start_q.size()), 64'd0);
    chk("done_q_drained", 64'(done_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
